// File: rtl/mem_req_dispatcher.sv
// mem_req_dispatcher: in-order request FIFO splitting memory requests into write and read paths
// Ports: m_axi_aclk/m_axi_areset clock and sync active-high reset; mem_req_* upstream request
// with valid/ready; wr_req_*/rd_req_* downstream handshakes sharing the head-entry req_* fields;
// wr_done acknowledges one write; wr_outstanding counts unacknowledged writes; queue_count occupancy.
module mem_req_dispatcher #(
  parameter int TCQ = 1,
  parameter int DEPTH = 4,
  parameter int MAX_WR_OUT = 15
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_areset,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [2:0]  mem_req_bar_hit,
  input  logic [31:0] mem_req_pcie_address,
  input  logic [7:0]  mem_req_byte_enable,
  input  logic        mem_req_write_readn,
  input  logic        mem_req_phys_func,
  input  logic [63:0] mem_req_write_data,
  output logic        wr_req_valid,
  input  logic        wr_req_ready,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [2:0]  req_bar_hit,
  output logic [31:0] req_pcie_address,
  output logic [7:0]  req_byte_enable,
  output logic        req_phys_func,
  output logic [63:0] req_write_data,
  input  logic        wr_done,
  output logic [3:0]  wr_outstanding,
  output logic [4:0]  queue_count
);
  localparam int AW = $clog2(DEPTH);
  logic [108:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic head_wr, empty, push, pop, wr_hs, dec;
  logic unused_tcq;
  assign unused_tcq = (TCQ != 0);
  assign {req_bar_hit, req_pcie_address, req_byte_enable, head_wr, req_phys_func, req_write_data} = mem[rd_ptr];
  assign empty = queue_count == 5'd0;
  assign mem_req_ready = !m_axi_areset && queue_count != 5'(DEPTH);
  // reads wait for every earlier write to be acknowledged so they never overtake one
  assign wr_req_valid = !empty && head_wr && wr_outstanding < 4'(MAX_WR_OUT);
  assign rd_req_valid = !empty && !head_wr && wr_outstanding == 4'd0;
  assign push = mem_req_valid && mem_req_ready;
  assign wr_hs = wr_req_valid && wr_req_ready;
  assign pop = wr_hs || (rd_req_valid && rd_req_ready);
  // a stray acknowledge with nothing outstanding is dropped rather than wrapping the counter
  assign dec = wr_done && wr_outstanding != 4'd0;
  always_ff @(posedge m_axi_aclk)
    if (push) mem[wr_ptr] <= {mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
                              mem_req_write_readn, mem_req_phys_func, mem_req_write_data};
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_count <= 5'd0;
      wr_outstanding <= 4'd0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      queue_count <= queue_count + 5'(push) - 5'(pop);
      wr_outstanding <= wr_outstanding + 4'(wr_hs) - 4'(dec);
    end
  end
endmodule
